mult_div_unit: RTL and testbench

Iterative 32-bit multiply/divide unit with architectural HI/LO registers, attached beside the execute stage of the pipelined MIPS core. It consumes the forwarded ALU operands of MULT/MULTU/DIV/DIVU/MTHI/MTLO issued in execute and produces HI/LO for MFHI/MFLO. While an operation is in flight, o_Busy drives the hazard unit so that dependent MFHI/MFLO or new mult/div instructions stall.

---
 rtl/mult_div_unit_if.sv | 17 +
 rtl/mult_div_unit.sv | 80 ++++++++
 tb/tb_mult_div_unit.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/mult_div_unit_if.sv
// mult_div_unit_if: issue/result bundle between the execute stage and the HI/LO multiply-divide unit.
interface mult_div_unit_if #(parameter int DATA_WIDTH = 32);
  logic start;
  logic [1:0] op;
  logic [DATA_WIDTH-1:0] src_a;
  logic [DATA_WIDTH-1:0] src_b;
  logic abort;
  logic write_hi;
  logic write_lo;
  logic [DATA_WIDTH-1:0] write_data;
  logic [DATA_WIDTH-1:0] hi;
  logic [DATA_WIDTH-1:0] lo;
  logic busy;
  logic done;
  modport master(output start, op, src_a, src_b, abort, write_hi, write_lo, write_data, input hi, lo, busy, done);
  modport slave(input start, op, src_a, src_b, abort, write_hi, write_lo, write_data, output hi, lo, busy, done);
endinterface

// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative shift-add multiply / restoring divide with HI/LO registers.
// Fixed latency: one bit per cycle on magnitudes, then a single sign-fixup cycle.
module mult_div_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH = 6
) (
  input logic i_CLK,
  input logic i_RST,
  mult_div_unit_if.slave bus
);
  localparam int W = DATA_WIDTH;
  localparam logic [1:0] IDLE = 2'd0, MUL = 2'd1, DIV = 2'd2, FIX = 2'd3;
  logic [1:0] state;
  logic [CNT_WIDTH-1:0] cnt;
  logic [W-1:0] a, b, hi, lo, abs_a, abs_b, quo, rem;
  logic [2*W-1:0] acc, prod;
  logic [W:0] mul_sum, div_t, div_diff;
  logic neg_q, neg_r, is_div, done, sgn, div_ge, last;
  // For divides, a keeps the raw dividend so divide-by-zero can return it in HI.
  always_comb begin
    sgn = ~bus.op[0];
    abs_a = sgn && bus.src_a[W-1] ? -bus.src_a : bus.src_a;
    abs_b = sgn && bus.src_b[W-1] ? -bus.src_b : bus.src_b;
    mul_sum = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, a} : '0);
    div_t = acc[2*W-1:W-1];
    div_diff = div_t - {1'b0, b};
    div_ge = ~div_diff[W];
    prod = neg_q ? -acc : acc;
    quo = b == '0 ? '1 : neg_q ? -acc[W-1:0] : acc[W-1:0];
    rem = b == '0 ? a : neg_r ? -acc[2*W-1:W] : acc[2*W-1:W];
    last = cnt == CNT_WIDTH'(W - 1);
  end
  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      state <= IDLE;
      cnt <= '0;
      a <= '0;
      b <= '0;
      acc <= '0;
      hi <= '0;
      lo <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      is_div <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        if (bus.start && !bus.abort) begin
          state <= bus.op[1] ? DIV : MUL;
          cnt <= '0;
          a <= bus.op[1] ? bus.src_a : abs_a;
          b <= abs_b;
          acc <= {{W{1'b0}}, bus.op[1] ? abs_a : abs_b};
          neg_q <= sgn & (bus.src_a[W-1] ^ bus.src_b[W-1]);
          neg_r <= sgn & bus.src_a[W-1];
          is_div <= bus.op[1];
        end else if (!bus.start) begin
          if (bus.write_hi) hi <= bus.write_data;
          if (bus.write_lo) lo <= bus.write_data;
        end
      end else if (bus.abort) begin
        state <= IDLE;
      end else if (state == FIX) begin
        state <= IDLE;
        done <= 1'b1;
        hi <= is_div ? rem : prod[2*W-1:W];
        lo <= is_div ? quo : prod[W-1:0];
      end else begin
        cnt <= cnt + CNT_WIDTH'(1);
        if (last) state <= FIX;
        acc <= state == MUL ? {mul_sum, acc[W-1:1]} : {div_ge ? div_diff[W-1:0] : div_t[W-1:0], acc[W-2:0], div_ge};
      end
    end
  end
  assign bus.hi = hi;
  assign bus.lo = lo;
  assign bus.busy = state != IDLE;
  assign bus.done = done;
endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: randomized and directed checks of mult_div_unit against a 64-bit arithmetic model.
module tb_mult_div_unit;
  logic clk, rst;
  int tests, fails;
  mult_div_unit_if #(.DATA_WIDTH(32)) m();
  mult_div_unit #(.DATA_WIDTH(32), .CNT_WIDTH(6)) dut(.i_CLK(clk), .i_RST(rst), .bus(m));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    if (o == 2'd0) return 64'(sx * sy);
    if (o == 2'd1) return {32'b0, x} * {32'b0, y};
    if (y == 32'd0) return {x, 32'hFFFFFFFF};
    if (o == 2'd2) return {32'(sx % sy), 32'(sx / sy)};
    return {x % y, x / y};
  endfunction
  task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    m.start = 1'b1;
    m.op = o;
    m.src_a = x;
    m.src_b = y;
    @(negedge clk);
    m.start = 1'b0;
  endtask
  task automatic wait_done(output int n, output bit ok);
    n = 0;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (m.busy) n++;
      if (m.done) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask
  task automatic test_reset;
    tests += 4;
    if (m.hi !== 32'd0) begin fails++; $display("FAIL reset_hi: got %h expected %h", m.hi, 32'd0); end
    if (m.lo !== 32'd0) begin fails++; $display("FAIL reset_lo: got %h expected %h", m.lo, 32'd0); end
    if (m.busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", m.busy); end
    if (m.done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b expected 0", m.done); end
  endtask
  task automatic test_directed;
    logic [1:0] ops [7] = '{2'd0, 2'd1, 2'd0, 2'd2, 2'd3, 2'd2, 2'd2};
    logic [31:0] as [7] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF9, 32'd100, 32'h80000000, 32'hFFFFFFF9};
    logic [31:0] bs [7] = '{32'd7, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd2, 32'd0, 32'hFFFFFFFF, 32'd0};
    logic [31:0] eh [7] = '{32'hFFFFFFFF, 32'hFFFFFFFE, 32'd0, 32'hFFFFFFFF, 32'd100, 32'd0, 32'hFFFFFFF9};
    logic [31:0] el [7] = '{32'hFFFFFFEB, 32'd1, 32'd1, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'h80000000, 32'hFFFFFFFF};
    int n;
    bit ok;
    @(negedge clk);
    for (int i = 0; i < 7; i++) begin
      issue(ops[i], as[i], bs[i]);
      wait_done(n, ok);
      tests += 4;
      if (!ok) begin fails++; $display("FAIL dir%0d_done: got no pulse required pulse", i); end
      if (n !== 33) begin fails++; $display("FAIL dir%0d_busy_cycles: got %0d expected 33", i, n); end
      if (m.hi !== eh[i]) begin fails++; $display("FAIL dir%0d_hi: got %h expected %h", i, m.hi, eh[i]); end
      if (m.lo !== el[i]) begin fails++; $display("FAIL dir%0d_lo: got %h expected %h", i, m.lo, el[i]); end
      @(negedge clk);
      tests++;
      if (m.done !== 1'b0) begin fails++; $display("FAIL dir%0d_done_width: got %b expected 0", i, m.done); end
    end
  endtask
  task automatic test_random;
    logic [1:0] o;
    logic [31:0] x, y;
    logic [63:0] e;
    int n;
    bit ok;
    for (int i = 0; i < 24; i++) begin
      o = 2'($urandom_range(0, 3));
      x = $urandom;
      y = $urandom;
      case ($urandom_range(0, 7))
        0: y = 32'd0;
        1: y = 32'hFFFFFFFF;
        2: y = $urandom_range(1, 15);
        3: x = 32'h80000000;
        default: ;
      endcase
      e = model(o, x, y);
      issue(o, x, y);
      wait_done(n, ok);
      tests += 3;
      if (!ok || n !== 33) begin fails++; $display("FAIL rnd%0d_timing: got done=%b cycles=%0d expected done=1 cycles=33", i, ok, n); end
      if (m.hi !== e[63:32]) begin fails++; $display("FAIL rnd%0d_hi op=%0d a=%h b=%h: got %h expected %h", i, o, x, y, m.hi, e[63:32]); end
      if (m.lo !== e[31:0]) begin fails++; $display("FAIL rnd%0d_lo op=%0d a=%h b=%h: got %h expected %h", i, o, x, y, m.lo, e[31:0]); end
    end
  endtask
  task automatic test_ignore_start;
    int n;
    bit ok;
    issue(2'd3, 32'd100, 32'd7);
    repeat (9) @(negedge clk);
    issue(2'd0, 32'd5, 32'd5);
    wait_done(n, ok);
    tests += 3;
    if (!ok || n !== 23) begin fails++; $display("FAIL ignore_start_timing: got done=%b cycles=%0d expected done=1 cycles=23", ok, n); end
    if (m.lo !== 32'd14) begin fails++; $display("FAIL ignore_start_lo: got %h expected %h", m.lo, 32'd14); end
    if (m.hi !== 32'd2) begin fails++; $display("FAIL ignore_start_hi: got %h expected %h", m.hi, 32'd2); end
  endtask
  task automatic test_mt_abort;
    logic [31:0] lo0;
    bit seen;
    @(negedge clk);
    lo0 = m.lo;
    m.write_hi = 1'b1;
    m.write_data = 32'h12345678;
    @(negedge clk);
    m.write_hi = 1'b0;
    tests += 2;
    if (m.hi !== 32'h12345678) begin fails++; $display("FAIL mthi_hi: got %h expected %h", m.hi, 32'h12345678); end
    if (m.lo !== lo0) begin fails++; $display("FAIL mthi_lo: got %h expected %h", m.lo, lo0); end
    issue(2'd0, 32'd3, 32'd5);
    repeat (4) @(negedge clk);
    m.write_lo = 1'b1;
    m.write_data = 32'hDEADBEEF;
    @(negedge clk);
    m.write_lo = 1'b0;
    tests++;
    if (m.lo !== lo0) begin fails++; $display("FAIL mtlo_busy_lo: got %h expected %h", m.lo, lo0); end
    repeat (14) @(negedge clk);
    m.abort = 1'b1;
    @(negedge clk);
    m.abort = 1'b0;
    tests += 4;
    if (m.busy !== 1'b0) begin fails++; $display("FAIL abort_busy: got %b expected 0", m.busy); end
    if (m.hi !== 32'h12345678) begin fails++; $display("FAIL abort_hi: got %h expected %h", m.hi, 32'h12345678); end
    if (m.lo !== lo0) begin fails++; $display("FAIL abort_lo: got %h expected %h", m.lo, lo0); end
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (m.done) seen = 1'b1;
      @(negedge clk);
    end
    if (seen) begin fails++; $display("FAIL abort_done: got pulse expected none"); end
    m.write_hi = 1'b1;
    m.write_lo = 1'b1;
    m.write_data = 32'hA5A55A5A;
    @(negedge clk);
    m.write_hi = 1'b0;
    m.write_lo = 1'b0;
    tests += 2;
    if (m.hi !== 32'hA5A55A5A) begin fails++; $display("FAIL mt_both_hi: got %h expected %h", m.hi, 32'hA5A55A5A); end
    if (m.lo !== 32'hA5A55A5A) begin fails++; $display("FAIL mt_both_lo: got %h expected %h", m.lo, 32'hA5A55A5A); end
    m.abort = 1'b1;
    issue(2'd1, 32'd9, 32'd9);
    m.abort = 1'b0;
    tests++;
    if (m.busy !== 1'b0) begin fails++; $display("FAIL idle_abort_start: got busy=%b expected 0", m.busy); end
  endtask
  task automatic test_reset_mid;
    logic [31:0] x, y;
    logic [63:0] e;
    int n;
    bit ok;
    issue(2'd0, 32'h7654321, 32'h89ABCDEF);
    repeat (14) @(negedge clk);
    rst = 1'b1;
    #1;
    tests += 3;
    if (m.busy !== 1'b0) begin fails++; $display("FAIL midrst_busy: got %b expected 0", m.busy); end
    if (m.hi !== 32'd0) begin fails++; $display("FAIL midrst_hi: got %h expected %h", m.hi, 32'd0); end
    if (m.lo !== 32'd0) begin fails++; $display("FAIL midrst_lo: got %h expected %h", m.lo, 32'd0); end
    @(negedge clk);
    rst = 1'b0;
    x = $urandom;
    y = $urandom;
    e = model(2'd0, x, y);
    issue(2'd0, x, y);
    wait_done(n, ok);
    tests += 2;
    if (!ok || n !== 33) begin fails++; $display("FAIL midrst_fresh_timing: got done=%b cycles=%0d expected done=1 cycles=33", ok, n); end
    if ({m.hi, m.lo} !== e) begin fails++; $display("FAIL midrst_fresh_result: got %h expected %h", {m.hi, m.lo}, e); end
  endtask
  task automatic test_back_to_back;
    logic [63:0] e1, e2;
    int n;
    bit ok;
    e1 = model(2'd2, 32'hFFFFFF00, 32'd7);
    e2 = model(2'd1, 32'hCAFEBABE, 32'h12345);
    issue(2'd2, 32'hFFFFFF00, 32'd7);
    wait_done(n, ok);
    tests++;
    if (!ok || {m.hi, m.lo} !== e1) begin fails++; $display("FAIL b2b_first: got %h expected %h", {m.hi, m.lo}, e1); end
    issue(2'd1, 32'hCAFEBABE, 32'h12345);
    wait_done(n, ok);
    tests += 2;
    if (!ok || n !== 33) begin fails++; $display("FAIL b2b_second_timing: got done=%b cycles=%0d expected done=1 cycles=33", ok, n); end
    if ({m.hi, m.lo} !== e2) begin fails++; $display("FAIL b2b_second: got %h expected %h", {m.hi, m.lo}, e2); end
  endtask
  initial begin
    tests = 0;
    fails = 0;
    rst = 1'b1;
    m.start = 1'b0;
    m.op = 2'd0;
    m.src_a = '0;
    m.src_b = '0;
    m.abort = 1'b0;
    m.write_hi = 1'b0;
    m.write_lo = 1'b0;
    m.write_data = '0;
    repeat (2) @(negedge clk);
    test_reset;
    rst = 1'b0;
    test_directed;
    test_random;
    test_ignore_start;
    test_mt_abort;
    test_reset_mid;
    test_back_to_back;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
